// File: rtl/seriell_schieber.sv
// seriell_schieber: multi-cycle shift/rotate unit, one bit position per clock.
// Slow-path counterpart to the single-cycle combinational rotator in the ALU.
//
// Parameters:
//   BREITE     - operand and result width in bits
//   LOG2BREITE - width of Stellen and of the step counter, log2(BREITE)
//
// Ports:
//   Takt     in   system clock, all state on the rising edge
//   Reset    in   synchronous, active-high reset
//   Start    in   request, accepted only while Bereit=1
//   Zahl     in   operand, sampled on the accepting edge
//   Stellen  in   shift count 0..BREITE-1, sampled on the accepting edge
//   Modus    in   000 rol, 001 ror, 010 lsl, 011 lsr, 100 asr, others leave data unchanged
//   Bereit   out  unit idle, can accept Start
//   Fertig   out  one-cycle pulse, Ergebnis newly valid
//   Ergebnis out  result, held until the next Fertig
module seriell_schieber #(
  parameter int unsigned BREITE     = 32,
  parameter int unsigned LOG2BREITE = 5
) (
  input  logic                  Takt,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [BREITE-1:0]     Zahl,
  input  logic [LOG2BREITE-1:0] Stellen,
  input  logic [2:0]            Modus,
  output logic                  Bereit,
  output logic                  Fertig,
  output logic [BREITE-1:0]     Ergebnis
);

  localparam logic [2:0] ModRotLinks  = 3'b000;
  localparam logic [2:0] ModRotRechts = 3'b001;
  localparam logic [2:0] ModLogLinks  = 3'b010;
  localparam logic [2:0] ModLogRechts = 3'b011;
  localparam logic [2:0] ModAriRechts = 3'b100;

  localparam logic [LOG2BREITE-1:0] ZaehlerEins = {{(LOG2BREITE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StLeerlauf = 2'b00,
    StSchieben = 2'b01,
    StFertig   = 2'b10
  } zustand_e;

  zustand_e              zustand_q, zustand_d;
  logic [BREITE-1:0]     daten_q, daten_d;
  logic [LOG2BREITE-1:0] zaehler_q, zaehler_d;
  logic [2:0]            modus_q, modus_d;
  logic [BREITE-1:0]     ergebnis_q, ergebnis_d;
  logic [BREITE-1:0]     schritt;

  // One-position step of the data register for the latched mode.
  always_comb begin
    schritt = daten_q;
    case (modus_q)
      ModRotLinks:  schritt = {daten_q[BREITE-2:0], daten_q[BREITE-1]};
      ModRotRechts: schritt = {daten_q[0], daten_q[BREITE-1:1]};
      ModLogLinks:  schritt = {daten_q[BREITE-2:0], 1'b0};
      ModLogRechts: schritt = {1'b0, daten_q[BREITE-1:1]};
      ModAriRechts: schritt = {daten_q[BREITE-1], daten_q[BREITE-1:1]};
      default:      schritt = daten_q;  // reserved modes pass the operand through
    endcase
  end

  always_comb begin
    zustand_d  = zustand_q;
    daten_d    = daten_q;
    zaehler_d  = zaehler_q;
    modus_d    = modus_q;
    ergebnis_d = ergebnis_q;
    Bereit     = 1'b0;
    Fertig     = 1'b0;

    unique case (zustand_q)
      StLeerlauf: begin
        Bereit = 1'b1;
        if (Start) begin
          daten_d   = Zahl;
          zaehler_d = Stellen;
          modus_d   = Modus;
          zustand_d = StSchieben;
        end
      end
      StSchieben: begin
        if (zaehler_q != '0) begin
          daten_d   = schritt;
          zaehler_d = zaehler_q - ZaehlerEins;
        end else begin
          ergebnis_d = daten_q;
          zustand_d  = StFertig;
        end
      end
      StFertig: begin
        Fertig    = 1'b1;
        zustand_d = StLeerlauf;
      end
      default: begin
        zustand_d = StLeerlauf;
      end
    endcase
  end

  always_ff @(posedge Takt) begin
    if (Reset) begin
      zustand_q  <= StLeerlauf;
      daten_q    <= '0;
      zaehler_q  <= '0;
      modus_q    <= '0;
      ergebnis_q <= '0;
    end else begin
      zustand_q  <= zustand_d;
      daten_q    <= daten_d;
      zaehler_q  <= zaehler_d;
      modus_q    <= modus_d;
      ergebnis_q <= ergebnis_d;
    end
  end

  assign Ergebnis = ergebnis_q;

endmodule

// File: tb/tb_seriell_schieber.sv
// Directed bench for seriell_schieber: every expected result is hand-computed.
module tb_seriell_schieber;

  logic        Takt = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Zahl = '0;
  logic [4:0]  Stellen = '0;
  logic [2:0]  Modus = '0;
  logic        Bereit;
  logic        Fertig;
  logic [31:0] Ergebnis;

  int n_checks = 0;
  int n_fail   = 0;

  seriell_schieber #(
    .BREITE    (32),
    .LOG2BREITE(5)
  ) dut (
    .Takt    (Takt),
    .Reset   (Reset),
    .Start   (Start),
    .Zahl    (Zahl),
    .Stellen (Stellen),
    .Modus   (Modus),
    .Bereit  (Bereit),
    .Fertig  (Fertig),
    .Ergebnis(Ergebnis)
  );

  always #5 Takt = ~Takt;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Takt);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    n_checks++;
    if (Bereit !== 1'b1) begin
      n_fail++; $display("FAIL reset_bereit: got %b want 1", Bereit);
    end
    n_checks++;
    if (Fertig !== 1'b0) begin
      n_fail++; $display("FAIL reset_fertig: got %b want 0", Fertig);
    end
    n_checks++;
    if (Ergebnis !== 32'h0) begin
      n_fail++; $display("FAIL reset_ergebnis: got %h want 00000000", Ergebnis);
    end
  endtask

  // Issue one request and check latency, result, handshake and hold behaviour.
  task automatic run_op(input string name, input logic [31:0] z, input logic [4:0] s,
                        input logic [2:0] m, input logic [31:0] erwartet);
    int n;
    logic gesehen;
    n_checks++;
    if (Bereit !== 1'b1) begin
      n_fail++; $display("FAIL %s_bereit_vor: got %b want 1", name, Bereit);
    end
    Start = 1'b1; Zahl = z; Stellen = s; Modus = m;
    tick();  // accepting edge
    Start = 1'b0; Zahl = ~z; Stellen = ~s; Modus = 3'b111;  // must not matter now
    n = 0;
    gesehen = 1'b0;
    while (n < 40 && !gesehen) begin
      tick();
      n++;
      if (Fertig === 1'b1) gesehen = 1'b1;
    end
    n_checks++;
    if (!gesehen || n != int'(s) + 1) begin
      n_fail++;
      $display("FAIL %s_latenz: got %0d cycles (seen=%b) want %0d", name, n, gesehen, s + 1);
    end
    n_checks++;
    if (Ergebnis !== erwartet) begin
      n_fail++; $display("FAIL %s_ergebnis: got %h want %h", name, Ergebnis, erwartet);
    end
    n_checks++;
    if (Bereit !== 1'b0) begin
      n_fail++; $display("FAIL %s_bereit_fertig: got %b want 0", name, Bereit);
    end
    tick();
    n_checks++;
    if (Fertig !== 1'b0 || Bereit !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_nachher: got fertig=%b bereit=%b want fertig=0 bereit=1",
               name, Fertig, Bereit);
    end
    n_checks++;
    if (Ergebnis !== erwartet) begin
      n_fail++; $display("FAIL %s_halten: got %h want %h", name, Ergebnis, erwartet);
    end
  endtask

  task automatic test_rotate();
    run_op("rol1", 32'h8000_0001, 5'd1, 3'b000, 32'h0000_0003);
    run_op("ror4", 32'h0000_0001, 5'd4, 3'b001, 32'h1000_0000);
    run_op("rol31", 32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000);
  endtask

  task automatic test_shift_31();
    run_op("asr31", 32'h8000_0000, 5'd31, 3'b100, 32'hFFFF_FFFF);
    run_op("lsr31", 32'h8000_0000, 5'd31, 3'b011, 32'h0000_0001);
    run_op("lsl31", 32'h8000_0000, 5'd31, 3'b010, 32'h0000_0000);
    run_op("asr_pos", 32'h4000_0000, 5'd3, 3'b100, 32'h0800_0000);
    run_op("reserved5", 32'h1234_5678, 5'd7, 3'b101, 32'h1234_5678);
  endtask

  task automatic test_null_stellen();
    logic [2:0] modi [6];
    modi = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("null_m%0d", modi[i]), 32'hDEAD_BEEF, 5'd0, modi[i], 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_start_ignoriert();
    int pulse;
    Start = 1'b1; Zahl = 32'h0000_000F; Stellen = 5'd8; Modus = 3'b010;
    tick();
    Start = 1'b0;
    pulse = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) begin
        Start = 1'b1; Zahl = 32'hFFFF_FFFF; Stellen = 5'd1; Modus = 3'b000;
      end else if (i == 3) begin
        Start = 1'b0;
      end
      tick();
      if (Fertig === 1'b1) begin
        pulse++;
        n_checks++;
        if (Ergebnis !== 32'h0000_0F00) begin
          n_fail++; $display("FAIL ignoriert_ergebnis: got %h want 00000f00", Ergebnis);
        end
      end
    end
    n_checks++;
    if (pulse != 1) begin
      n_fail++; $display("FAIL ignoriert_pulse: got %0d want 1", pulse);
    end
  endtask

  task automatic test_reset_mitten();
    int pulse;
    Start = 1'b1; Zahl = 32'h0000_00FF; Stellen = 5'd20; Modus = 3'b010;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (Bereit !== 1'b1 || Ergebnis !== 32'h0 || Fertig !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mitten: got bereit=%b fertig=%b erg=%h want 1 0 00000000",
               Bereit, Fertig, Ergebnis);
    end
    pulse = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Fertig === 1'b1) pulse++;
    end
    n_checks++;
    if (pulse != 0) begin
      n_fail++; $display("FAIL reset_mitten_fertig: got %0d pulses want 0", pulse);
    end
  endtask

  task automatic test_reset_und_start();
    int pulse;
    Reset = 1'b1; Start = 1'b1; Zahl = 32'h0000_0001; Stellen = 5'd2; Modus = 3'b000;
    tick();
    Reset = 1'b0; Start = 1'b0;
    n_checks++;
    if (Bereit !== 1'b1) begin
      n_fail++; $display("FAIL reset_start_bereit: got %b want 1", Bereit);
    end
    pulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Fertig === 1'b1) pulse++;
    end
    n_checks++;
    if (pulse != 0) begin
      n_fail++; $display("FAIL reset_start_fertig: got %0d pulses want 0", pulse);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 32'hA5A5_A5A5, 5'd1, 3'b001, 32'hD2D2_D2D2);
    run_op("b2b_b", 32'hF000_0000, 5'd4, 3'b100, 32'hFF00_0000);
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift_31();
    test_null_stellen();
    test_start_ignoriert();
    test_reset_mitten();
    test_rotate();
    test_reset_und_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
